// File: rtl/tm_step_sequencer.sv
// tm_step_sequencer: paces the Turing machine Next handshake for single-step, N-step and free-run operation
module tm_step_sequencer #(
  parameter int SW = 4,
  parameter int CW = 16,
  parameter logic [SW-1:0] ST_READ_DATA = 4'd10,
  parameter logic [SW-1:0] ST_READ_DIR = 4'd12,
  parameter logic [SW-1:0] ST_STOP = 4'd14,
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic step,
  input  logic halt_req,
  input  logic clear,
  input  logic [CW-1:0] step_limit,
  input  logic [SW-1:0] tm_state,
  input  logic compute_done,
  output logic next_out,
  output logic busy,
  output logic done,
  output logic [CW-1:0] step_count,
  output logic limit_hit,
  output logic timeout_err,
  output logic [2:0] seq_state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_ASSERT = 3'd2, S_RELEASE = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5
  } state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic cont, cont_n, lim_n, go_run;
  logic [CW-1:0] cnt_n, cnt_inc;
  logic [WW-1:0] wd;
  assign seq_state = state;
  // next state plus step counter and limit flag updates; watchdog expiry overrides everything
  always_comb begin
    state_n = state;
    cont_n = cont;
    cnt_n = step_count;
    lim_n = limit_hit;
    go_run = run && !halt_req && !limit_hit;
    cnt_inc = &step_count ? step_count : step_count + 1'b1;
    case (state)
      S_IDLE: begin
        if (clear) begin
          cnt_n = '0;
          lim_n = 1'b0;
        end
        if (compute_done || tm_state == ST_STOP) state_n = S_DONE;
        else if (go_run || step) begin
          state_n = S_ARM;
          cont_n = go_run;
        end
      end
      S_ARM: state_n = compute_done ? S_DONE : tm_state == ST_READ_DATA ? S_ASSERT : S_ARM;
      S_ASSERT: state_n = tm_state == ST_READ_DIR ? S_RELEASE : S_ASSERT;
      S_RELEASE: begin
        if (tm_state != ST_READ_DIR) begin
          cnt_n = cnt_inc;
          if (compute_done) state_n = S_DONE;
          else if (step_limit != '0 && cnt_inc == step_limit) begin
            lim_n = 1'b1;
            state_n = S_IDLE;
          end else state_n = (!cont || halt_req || !run) ? S_IDLE : S_ARM;
        end
      end
      default: state_n = state;
    endcase
    if (busy && wd == WW'(TIMEOUT - 1)) begin
      state_n = S_ERR;
      cnt_n = step_count;
      lim_n = limit_hit;
    end
  end
  // state, counters and registered outputs decoded from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cont <= 1'b0;
      step_count <= '0;
      limit_hit <= 1'b0;
      wd <= '0;
      next_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cont <= cont_n;
      step_count <= cnt_n;
      limit_hit <= lim_n;
      wd <= (state_n == S_ARM && state != S_ARM) ? '0 : busy ? wd + 1'b1 : wd;
      next_out <= state_n == S_ASSERT;
      busy <= state_n inside {S_ARM, S_ASSERT, S_RELEASE};
      done <= state_n == S_DONE;
      timeout_err <= state_n == S_ERR;
    end
  end
endmodule
